aes_trace_sequencer: RTL

Batch controller placed between the SASEBO-GIII host interface and the AES encryption core. It loads a key once, then runs a programmed number of encryptions back-to-back. Each encryption produces an oscilloscope trigger aligned to the data launch, and the block returns every ciphertext to the host. An optional chained mode feeds each ciphertext back as the next plaintext, so long trace campaigns need no host traffic per run.

---
 rtl/aes_seq_pkg.sv | 28 ++
 rtl/aes_seq_watchdog.sv | 38 +++
 rtl/aes_trace_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and sizes for the AES trace-campaign sequencer.
// The state enum is ordered by the flow of a normal batch.
package aes_seq_pkg;

    localparam int KEY_W       = 128;
    localparam int CNT_W       = 16;
    localparam int DLY_W       = 8;
    localparam int WD_W        = 16;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEY_LOAD,
        ST_KEY_WAIT,
        ST_ARM,
        ST_LAUNCH,
        ST_DATA_WAIT,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    // The scope trigger spans the launch strobe and the whole wait for ciphertext.
    function automatic logic is_trig_state(input seq_state_e s);
        return (s == ST_LAUNCH) || (s == ST_DATA_WAIT);
    endfunction

endpackage

// File: rtl/aes_seq_watchdog.sv
// Loadable down-counter shared by the core-response watchdog and the ARM delay.
// Counting stops at zero so the zero flag stays asserted until the next load.
module aes_seq_watchdog
    import aes_seq_pkg::*;
#(
    parameter int W = WD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/aes_trace_sequencer.sv
// Batch controller between the host interface and the AES core: one key load,
// then run_count triggered encryptions, optionally chaining ciphertext into plaintext.
module aes_trace_sequencer
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_in,
    input  logic [KEY_W-1:0] pt_in,
    input  logic [CNT_W-1:0] run_count,
    input  logic             chain_mode,
    input  logic [DLY_W-1:0] trig_delay,
    output logic [KEY_W-1:0] aes_kin,
    output logic [KEY_W-1:0] aes_din,
    output logic             aes_krdy,
    output logic             aes_drdy,
    output logic             aes_en,
    input  logic             aes_kvld,
    input  logic             aes_dvld,
    input  logic             aes_bsy,
    input  logic [KEY_W-1:0] aes_dout,
    output logic             trig,
    output logic [KEY_W-1:0] ct_out,
    output logic             ct_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] runs_done,
    output logic             timeout_err
);

    localparam logic [WD_W-1:0] WD_TIMEOUT = WD_W'(TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] pt_q, pt_d;
    logic [KEY_W-1:0] ct_q, ct_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] runs_q, runs_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             chain_q, chain_d;
    logic             krdy_q, krdy_d;
    logic             drdy_q, drdy_d;
    logic             trig_q, trig_d;
    logic             ctv_q, ctv_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             terr_q, terr_d;

    logic             wd_load, wd_en, wd_zero;
    logic [WD_W-1:0]  wd_val;
    logic [WD_W-1:0]  dly_ext;
    logic [CNT_W-1:0] runs_inc;

    assign dly_ext  = {{(WD_W - DLY_W){1'b0}}, dly_q};
    assign runs_inc = runs_q + 1'b1;

    aes_seq_watchdog #(.W(WD_W)) u_watchdog (
        .clk      (CLK),
        .rst_n    (RSTn),
        .load     (wd_load),
        .en       (wd_en),
        .load_val (wd_val),
        .zero     (wd_zero)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        cnt_d   = cnt_q;
        runs_d  = runs_q;
        dly_d   = dly_q;
        chain_d = chain_q;
        terr_d  = terr_q;
        ctv_d   = 1'b0;
        wd_load = 1'b0;
        wd_en   = 1'b0;
        wd_val  = WD_TIMEOUT;

        // abort wins over every core response, including a same-cycle aes_dvld
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        key_d   = key_in;
                        pt_d    = pt_in;
                        cnt_d   = run_count;
                        chain_d = chain_mode;
                        dly_d   = trig_delay;
                        runs_d  = '0;
                        terr_d  = 1'b0;
                        state_d = (run_count == '0) ? ST_DONE : ST_KEY_LOAD;
                    end
                end
                ST_KEY_LOAD: begin
                    state_d = ST_KEY_WAIT;
                    wd_load = 1'b1;
                end
                ST_KEY_WAIT: begin
                    if (aes_kvld) begin
                        state_d = ST_ARM;
                        wd_load = 1'b1;
                        wd_val  = dly_ext;
                    end else if (wd_zero) begin
                        state_d = ST_ERR;
                        terr_d  = 1'b1;
                    end else begin
                        wd_en = 1'b1;
                    end
                end
                ST_ARM: begin
                    if (wd_zero && !aes_bsy) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        wd_en = 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state_d = ST_DATA_WAIT;
                    wd_load = 1'b1;
                end
                ST_DATA_WAIT: begin
                    if (aes_dvld) begin
                        ct_d    = aes_dout;
                        ctv_d   = 1'b1;
                        state_d = ST_NEXT;
                    end else if (wd_zero) begin
                        state_d = ST_ERR;
                        terr_d  = 1'b1;
                    end else begin
                        wd_en = 1'b1;
                    end
                end
                ST_NEXT: begin
                    runs_d = runs_inc;
                    if (chain_q) begin
                        pt_d = ct_q;
                    end
                    if (runs_inc == cnt_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARM;
                        wd_load = 1'b1;
                        wd_val  = dly_ext;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ERR:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they align with it.
        krdy_d = (state_d == ST_KEY_LOAD);
        drdy_d = (state_d == ST_LAUNCH);
        trig_d = is_trig_state(state_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            cnt_q   <= '0;
            runs_q  <= '0;
            dly_q   <= '0;
            chain_q <= 1'b0;
            krdy_q  <= 1'b0;
            drdy_q  <= 1'b0;
            trig_q  <= 1'b0;
            ctv_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            cnt_q   <= cnt_d;
            runs_q  <= runs_d;
            dly_q   <= dly_d;
            chain_q <= chain_d;
            krdy_q  <= krdy_d;
            drdy_q  <= drdy_d;
            trig_q  <= trig_d;
            ctv_q   <= ctv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign aes_kin     = key_q;
    assign aes_din     = pt_q;
    assign aes_krdy    = krdy_q;
    assign aes_drdy    = drdy_q;
    assign aes_en      = busy_q;
    assign trig        = trig_q;
    assign ct_out      = ct_q;
    assign ct_valid    = ctv_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign runs_done   = runs_q;
    assign timeout_err = terr_q;

endmodule
